// File: rtl/vend_dispenser.sv
// Dispense stage behind the vending FSM: queues vend pulses, runs the motor for a
// fixed time, confirms delivery on the drop sensor and latches a fault on timeout.
module vend_dispenser #(
  parameter int MOTOR_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int PEND_W         = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_valid,
  input  logic              io_drop,
  input  logic              io_clear_fault,
  output logic              io_motor,
  output logic              io_busy,
  output logic              io_dispensed,
  output logic              io_fault,
  output logic              io_overflow,
  output logic [PEND_W-1:0] io_pending
);

  // state     | meaning
  // IDLE      | motor off; starts a vend when the queue is non-empty
  // RUN       | motor on for MOTOR_CYCLES cycles; remembers any drop seen
  // WAIT_DROP | motor off; waits up to TIMEOUT_CYCLES for the drop sensor
  // FAULT     | drop never arrived; held until io_clear_fault
  typedef enum logic [1:0] {IDLE, RUN, WAIT_DROP, FAULT} state_t;

  localparam logic [7:0]        M_LOAD = 8'(MOTOR_CYCLES - 1);
  localparam logic [7:0]        T_LOAD = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [PEND_W-1:0] P_MAX  = '1;

  state_t            state, state_nxt;
  logic [7:0]        mcnt, mcnt_nxt;
  logic [7:0]        tcnt, tcnt_nxt;
  logic              drop_seen, drop_seen_nxt;
  logic              disp_q, disp_nxt;
  logic              ovf_q, ovf_nxt;
  logic [PEND_W-1:0] pending, pending_nxt;
  logic              deq;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mcnt      <= '0;
      tcnt      <= '0;
      drop_seen <= 1'b0;
      disp_q    <= 1'b0;
      ovf_q     <= 1'b0;
      pending   <= '0;
    end else begin
      state     <= state_nxt;
      mcnt      <= mcnt_nxt;
      tcnt      <= tcnt_nxt;
      drop_seen <= drop_seen_nxt;
      disp_q    <= disp_nxt;
      ovf_q     <= ovf_nxt;
      pending   <= pending_nxt;
    end
  end

  always_comb begin
    deq           = (state == IDLE) && (pending != '0);
    pending_nxt   = pending;
    ovf_nxt       = 1'b0;
    state_nxt     = state;
    mcnt_nxt      = mcnt;
    tcnt_nxt      = tcnt;
    drop_seen_nxt = drop_seen;
    disp_nxt      = 1'b0;

    // simultaneous enqueue and dequeue cancel out
    if (io_valid && !deq) begin
      if (pending == P_MAX) ovf_nxt = 1'b1;
      else                  pending_nxt = pending + 1'b1;
    end else if (!io_valid && deq) begin
      pending_nxt = pending - 1'b1;
    end

    case (state)
      IDLE: begin
        if (deq) begin
          state_nxt     = RUN;
          mcnt_nxt      = M_LOAD;
          drop_seen_nxt = 1'b0;
        end
      end
      RUN: begin
        if (io_drop) drop_seen_nxt = 1'b1;
        if (mcnt == 8'd0) begin
          if (drop_seen || io_drop) begin
            state_nxt = IDLE;
            disp_nxt  = 1'b1;
          end else begin
            state_nxt = WAIT_DROP;
            tcnt_nxt  = T_LOAD;
          end
        end else begin
          mcnt_nxt = mcnt - 8'd1;
        end
      end
      WAIT_DROP: begin
        // a drop on the last timeout cycle still counts as delivered
        if (io_drop) begin
          state_nxt = IDLE;
          disp_nxt  = 1'b1;
        end else if (tcnt == 8'd0) begin
          state_nxt = FAULT;
        end else begin
          tcnt_nxt = tcnt - 8'd1;
        end
      end
      FAULT: begin
        if (io_clear_fault) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign io_motor     = (state == RUN);
  assign io_busy      = (state != IDLE);
  assign io_fault     = (state == FAULT);
  assign io_dispensed = disp_q;
  assign io_overflow  = ovf_q;
  assign io_pending   = pending;

endmodule

// File: tb/tb_vend_dispenser.sv
// Directed, table-driven bench for vend_dispenser with default parameters;
// each table row holds inputs and expected outputs for a run of cycles.
module tb_vend_dispenser;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       io_valid = 1'b0;
  logic       io_drop = 1'b0;
  logic       io_clear_fault = 1'b0;
  logic       io_motor, io_busy, io_dispensed, io_fault, io_overflow;
  logic [1:0] io_pending;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         n;
    logic       v;
    logic       d;
    logic       c;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[$];

  vend_dispenser #(.MOTOR_CYCLES(8), .TIMEOUT_CYCLES(64), .PEND_W(2)) dut (
    .clk(clk),
    .reset(reset),
    .io_valid(io_valid),
    .io_drop(io_drop),
    .io_clear_fault(io_clear_fault),
    .io_motor(io_motor),
    .io_busy(io_busy),
    .io_dispensed(io_dispensed),
    .io_fault(io_fault),
    .io_overflow(io_overflow),
    .io_pending(io_pending)
  );

  always #5 clk = ~clk;

  // expected = {motor, busy, dispensed, fault, overflow, pending[1:0]}
  task automatic add(input int n, input logic v, input logic d, input logic c,
                     input logic m, input logic b, input logic ds, input logic f,
                     input logic o, input logic [1:0] p);
    vec_t r;
    r.n = n; r.v = v; r.d = d; r.c = c;
    r.exp = {m, b, ds, f, o, p};
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input int idx, input logic [6:0] exp);
    logic [6:0] act;
    act = {io_motor, io_busy, io_dispensed, io_fault, io_overflow, io_pending};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got m/b/d/f/o/p=%b want %b", name, idx, act, exp);
    end
  endtask

  initial begin
    int step;

    // single vend, drop during WAIT_DROP; drop in IDLE ignored
    add(10,0,0,0, 0,0,0,0,0,2'd0);
    add(2, 0,1,0, 0,0,0,0,0,2'd0);
    add(1, 1,0,0, 0,0,0,0,0,2'd0);
    add(1, 0,0,0, 0,0,0,0,0,2'd1);
    add(8, 0,0,0, 1,1,0,0,0,2'd0);
    add(2, 0,0,0, 0,1,0,0,0,2'd0);
    add(1, 0,1,0, 0,1,0,0,0,2'd0);
    add(1, 0,0,0, 0,0,1,0,0,2'd0);
    add(3, 0,0,0, 0,0,0,0,0,2'd0);
    // drop during RUN cycle 3: full motor time, no WAIT_DROP
    add(1, 1,0,0, 0,0,0,0,0,2'd0);
    add(1, 0,0,0, 0,0,0,0,0,2'd1);
    add(2, 0,0,0, 1,1,0,0,0,2'd0);
    add(1, 0,1,0, 1,1,0,0,0,2'd0);
    add(5, 0,0,0, 1,1,0,0,0,2'd0);
    add(1, 0,0,0, 0,0,1,0,0,2'd0);
    add(2, 0,0,0, 0,0,0,0,0,2'd0);
    // request coincides with dequeue; back-to-back vends, drop on last RUN cycle
    add(1, 1,0,0, 0,0,0,0,0,2'd0);
    add(1, 1,0,0, 0,0,0,0,0,2'd1);
    add(7, 0,0,0, 1,1,0,0,0,2'd1);
    add(1, 0,1,0, 1,1,0,0,0,2'd1);
    add(1, 0,0,0, 0,0,1,0,0,2'd1);
    add(7, 0,0,0, 1,1,0,0,0,2'd0);
    add(1, 0,1,0, 1,1,0,0,0,2'd0);
    add(1, 0,0,0, 0,0,1,0,0,2'd0);
    add(2, 0,0,0, 0,0,0,0,0,2'd0);
    // drop on the final timeout cycle wins over the timeout
    add(1, 1,0,0, 0,0,0,0,0,2'd0);
    add(1, 0,0,0, 0,0,0,0,0,2'd1);
    add(8, 0,0,0, 1,1,0,0,0,2'd0);
    add(63,0,0,0, 0,1,0,0,0,2'd0);
    add(1, 0,1,0, 0,1,0,0,0,2'd0);
    add(1, 0,0,0, 0,0,1,0,0,2'd0);
    add(1, 0,0,0, 0,0,0,0,0,2'd0);
    // timeout into FAULT, queue while faulted, clear resumes
    add(1, 1,0,0, 0,0,0,0,0,2'd0);
    add(1, 0,0,0, 0,0,0,0,0,2'd1);
    add(8, 0,0,0, 1,1,0,0,0,2'd0);
    add(64,0,0,0, 0,1,0,0,0,2'd0);
    add(1, 1,0,0, 0,1,0,1,0,2'd0);
    add(1, 1,0,0, 0,1,0,1,0,2'd1);
    add(1, 0,0,1, 0,1,0,1,0,2'd2);
    add(1, 0,0,0, 0,0,0,0,0,2'd2);
    add(7, 0,0,0, 1,1,0,0,0,2'd1);
    add(1, 0,1,0, 1,1,0,0,0,2'd1);
    add(1, 0,0,0, 0,0,1,0,0,2'd1);
    add(8, 0,0,0, 1,1,0,0,0,2'd0);
    add(64,0,0,0, 0,1,0,0,0,2'd0);
    add(3, 0,0,0, 0,1,0,1,0,2'd0);
    // five requests in FAULT: saturate at 3, two overflow pulses
    add(1, 1,0,0, 0,1,0,1,0,2'd0);
    add(1, 1,0,0, 0,1,0,1,0,2'd1);
    add(1, 1,0,0, 0,1,0,1,0,2'd2);
    add(1, 1,0,0, 0,1,0,1,0,2'd3);
    add(1, 1,0,0, 0,1,0,1,1,2'd3);
    add(1, 0,0,0, 0,1,0,1,1,2'd3);
    add(2, 0,1,0, 0,1,0,1,0,2'd3);
    add(1, 0,0,1, 0,1,0,1,0,2'd3);
    add(1, 0,0,0, 0,0,0,0,0,2'd3);
    add(4, 0,0,0, 1,1,0,0,0,2'd2);

    #2 reset = 1'b0;
    #1 chk("reset_state", 0, 7'b0);
    repeat (2) @(negedge clk);
    chk("reset_held", 0, 7'b0);
    reset = 1'b1;

    step = 0;
    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        @(negedge clk);
        io_valid       = tbl[i].v;
        io_drop        = tbl[i].d;
        io_clear_fault = tbl[i].c;
        chk("table", step, tbl[i].exp);
        step++;
      end
    end

    // async reset in the middle of the fifth motor cycle
    @(posedge clk);
    io_valid = 1'b0; io_drop = 1'b0; io_clear_fault = 1'b0;
    #1 chk("pre_reset_run", 0, 7'b1100010);
    #1 reset = 1'b0;
    #1 chk("async_reset_midrun", 0, 7'b0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("post_reset_idle", k, 7'b0);
    end
    io_valid = 1'b1;
    @(negedge clk);
    io_valid = 1'b0;
    chk("new_vend_pend", 0, 7'b0000001);
    @(negedge clk);
    chk("new_vend_run", 0, 7'b1100000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_dispenser.md
Name: vend_dispenser

Overview:
- Downstream stage of the vending FSM.
- Consumes the one-cycle io_valid vend pulse that the vending FSM emits on reaching its paid state.
- Queues pending vends, drives the dispense motor for a fixed time, then confirms delivery via a drop sensor with a timeout.
- A missed drop latches a fault that stalls dispensing until software clears it; vend requests keep queueing meanwhile.

Parameters:
MOTOR_CYCLES, 8, cycles io_motor is held high per vend (legal 1..256)
TIMEOUT_CYCLES, 64, cycles to wait for io_drop after motor stops (legal 1..256)
PEND_W, 2, width of pending-vend counter; saturates at 2**PEND_W-1

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
io_valid  input  1  vend request from vending FSM; each high cycle = one vend
io_drop  input  1  product-drop sensor, synchronous, level
io_clear_fault  input  1  leaves FAULT state when high
io_motor  output  1  dispense motor enable
io_busy  output  1  high when state != IDLE
io_dispensed  output  1  one-cycle pulse per confirmed drop
io_fault  output  1  high in FAULT state
io_overflow  output  1  one-cycle pulse when a request is dropped at saturation
io_pending  output  PEND_W  queued vends not yet started

Behaviour:
- Reset (reset==0, async):
  - state=IDLE; pending=0; all counters=0.
  - io_motor, io_busy, io_dispensed, io_fault, io_overflow = 0; io_pending = 0.
  - Reset mid-RUN drops io_motor immediately, without waiting for a clock edge.
- All state and outputs are registered; outputs are decoded from registered state or flags.
- Pending counter, evaluated each edge:
  - inc = io_valid; dec = (state==IDLE && pending!=0).
  - inc and dec together: pending unchanged.
  - inc while pending==max and no dec: pending stays at max; io_overflow=1 next cycle.
  - Pending accumulates in every state, including FAULT.
- IDLE:
  - If pending!=0: go to RUN, load mcnt=MOTOR_CYCLES-1, clear drop_seen.
  - A request arriving into an empty queue reaches RUN 2 edges after io_valid is sampled.
- RUN:
  - io_motor=1.
  - io_drop high on any RUN cycle sets drop_seen.
  - mcnt decrements each cycle; while mcnt==0:
    - if drop_seen or io_drop: go to IDLE and pulse io_dispensed;
    - else: go to WAIT_DROP, load tcnt=TIMEOUT_CYCLES-1.
  - io_motor is high for exactly MOTOR_CYCLES cycles.
- WAIT_DROP:
  - io_motor=0.
  - io_drop high: go to IDLE, io_dispensed=1 on the following cycle.
  - Else if tcnt==0: go to FAULT.
  - Else: tcnt decrements.
  - io_drop on the tcnt==0 cycle counts as success; drop takes priority over timeout.
- FAULT:
  - io_fault=1, io_motor=0, io_busy=1.
  - io_clear_fault high: go to IDLE; pending is retained, so dispensing resumes on the next edge.
  - io_clear_fault has no effect in other states.
- Back-to-back vends:
  - After io_dispensed, IDLE lasts exactly one cycle before the next RUN if pending!=0.
  - io_busy drops for that cycle.
- io_drop outside RUN/WAIT_DROP is ignored.
- io_dispensed and io_overflow are never high for two consecutive cycles from a single event.

Test Plan:
1. Reset released, single io_valid pulse at cycle 10, io_drop at cycle 22 (defaults) -> io_pending=1 at 11, motor high cycles 12-19, WAIT_DROP from 20, io_dispensed=1 at cycle 23, io_pending=0, io_busy=0 afterwards.
2. io_drop pulsed during RUN cycle 3 -> motor still runs full 8 cycles, io_dispensed pulses the cycle after motor stops, no WAIT_DROP visit.
3. No io_drop after vend -> fault after 8 motor + 64 wait cycles: io_fault=1; two more io_valid pulses give io_pending=2; io_clear_fault for one cycle -> next edge IDLE, then RUN, io_pending=1.
4. Five io_valid pulses on consecutive cycles while in FAULT (PEND_W=2) -> io_pending saturates at 3, io_overflow pulses twice, no wrap to 0.
5. io_valid coincides with IDLE dequeue (pending=1) -> io_pending stays 1, next vend starts after current one completes.
6. reset driven low mid-RUN (motor count 4) between clock edges -> io_motor and io_busy go 0 immediately; after release, no motor activity until a new io_valid.
